note_recorder: RTL and testbench

- Records live key input as note/duration entries in the song memory format that the song reader plays back. It is the writer at the far end of the song-memory interface that the song reader reads.
- Sits between the debounced keypad/switch logic and the write port of the song RAM.
- Timing comes from the same beat pulse that drives the note players.
- Each recorded song occupies one song slot; the slot ends with a terminator entry.

---
 rtl/note_recorder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_note_recorder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_recorder.sv
// ---------------------------------------------------------------------------
// note_recorder
//   Records live key input into one slot of the song RAM as a list of
//   {note, duration} entries terminated by an all-zero entry, in the same
//   format the song reader plays back. Durations are counted in beats.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   record_en    level; a sampled rising edge arms a take, falling edge ends it
//   song_select  slot to record into, latched when the take is armed
//   key_valid    a key is currently held
//   key_note     note of the held key (1..63)
//   beat         one-cycle beat pulse
//   wr_en        one-cycle write strobe to the song RAM
//   wr_addr      {slot[1:0], index[4:0]}
//   wr_data      {4'b0, note[5:0], duration[5:0]}; note 0 = rest, all 0 = end
//   recording    high while a take is in progress (ARMED..FINISH)
//   full         set once the last non-terminator entry has been written
//   note_count   entries written in the current take, terminator excluded
//   dbg_state    current FSM state (encoding of state_t)
//
// Handshake: wr_en is a pure strobe with no back-pressure. wr_addr and
// wr_data are only meaningful in the cycle wr_en is high; at most one write
// is issued per cycle.
// ---------------------------------------------------------------------------
module note_recorder #(
    parameter int INDEX_WIDTH = 5,
    parameter int MAX_DUR     = 63
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   record_en,
    input  logic [1:0]             song_select,
    input  logic                   key_valid,
    input  logic [5:0]             key_note,
    input  logic                   beat,
    output logic                   wr_en,
    output logic [INDEX_WIDTH+1:0] wr_addr,
    output logic [15:0]            wr_data,
    output logic                   recording,
    output logic                   full,
    output logic [INDEX_WIDTH-1:0] note_count,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        HOLD   = 3'd2,
        REST   = 3'd3,
        CLOSE  = 3'd4,
        FINISH = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [5:0]             DUR_MAX    = 6'(MAX_DUR);
    // The final index of a slot is reserved for the terminator.
    localparam logic [INDEX_WIDTH-1:0] LAST_ENTRY = '1;

    state_t                 state, state_n;
    state_t                 p_next, p_next_n;
    logic                   rec_q;
    logic [1:0]             slot, slot_n;
    logic [INDEX_WIDTH-1:0] index, index_n;
    logic [INDEX_WIDTH-1:0] count_n;
    logic                   full_n;
    logic [5:0]             dur, dur_n;
    logic [5:0]             note, note_n;
    logic [5:0]             p_note, p_note_n;
    logic [5:0]             p_dur, p_dur_n;
    logic                   wr_en_n;
    logic [INDEX_WIDTH+1:0] wr_addr_n;
    logic [15:0]            wr_data_n;
    logic                   recording_n;

    logic                   rise, fall;
    logic [5:0]             dur_inc;
    logic [5:0]             close_dur;
    logic                   do_entry;
    logic [5:0]             e_note, e_dur;

    assign rise      = record_en & ~rec_q;
    assign fall      = ~record_en & rec_q;
    // A beat arriving in the cycle of a transition belongs to the old segment.
    assign dur_inc   = dur + 6'(beat);
    assign close_dur = (dur_inc == 6'd0) ? 6'd1 : dur_inc;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        // The edge detector follows record_en even through reset, so a level
        // held across reset does not look like a fresh rising edge.
        rec_q <= record_en;
        if (reset) begin
            state      <= IDLE;
            p_next     <= IDLE;
            slot       <= 2'd0;
            index      <= '0;
            note_count <= '0;
            full       <= 1'b0;
            dur        <= 6'd0;
            note       <= 6'd0;
            p_note     <= 6'd0;
            p_dur      <= 6'd0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 16'd0;
            recording  <= 1'b0;
        end else begin
            state      <= state_n;
            p_next     <= p_next_n;
            slot       <= slot_n;
            index      <= index_n;
            note_count <= count_n;
            full       <= full_n;
            dur        <= dur_n;
            note       <= note_n;
            p_note     <= p_note_n;
            p_dur      <= p_dur_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            recording  <= recording_n;
        end
    end

    always_comb begin
        state_n   = state;
        p_next_n  = p_next;
        slot_n    = slot;
        index_n   = index;
        count_n   = note_count;
        full_n    = full;
        dur_n     = dur;
        note_n    = note;
        p_note_n  = p_note;
        p_dur_n   = p_dur;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        do_entry  = 1'b0;
        e_note    = 6'd0;
        e_dur     = 6'd0;

        case (state)
            IDLE: begin
                if (rise) begin
                    slot_n   = song_select;
                    index_n  = '0;
                    count_n  = '0;
                    full_n   = 1'b0;
                    dur_n    = 6'd0;
                    note_n   = 6'd0;
                    state_n  = ARMED;
                end
            end
            ARMED: begin
                if (fall) begin
                    state_n = FINISH;
                end else if (key_valid) begin
                    note_n  = key_note;
                    dur_n   = 6'd0;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (fall) begin
                    p_note_n = note;
                    p_dur_n  = close_dur;
                    p_next_n = FINISH;
                    state_n  = CLOSE;
                end else if (!key_valid) begin
                    p_note_n = note;
                    p_dur_n  = close_dur;
                    p_next_n = REST;
                    dur_n    = 6'd0;
                    state_n  = CLOSE;
                end else if (key_note != note) begin
                    p_note_n = note;
                    p_dur_n  = close_dur;
                    p_next_n = HOLD;
                    note_n   = key_note;
                    dur_n    = 6'd0;
                    state_n  = CLOSE;
                end else if (dur_inc == DUR_MAX) begin
                    // Long note: emit a saturated entry and keep holding.
                    do_entry = 1'b1;
                    e_note   = note;
                    e_dur    = DUR_MAX;
                    dur_n    = 6'd0;
                end else begin
                    dur_n = dur_inc;
                end
            end
            REST: begin
                if (fall) begin
                    if (dur_inc != 6'd0) begin
                        p_note_n = 6'd0;
                        p_dur_n  = dur_inc;
                        p_next_n = FINISH;
                        state_n  = CLOSE;
                    end else begin
                        state_n = FINISH;
                    end
                end else if (key_valid) begin
                    note_n = key_note;
                    dur_n  = 6'd0;
                    if (dur_inc != 6'd0) begin
                        p_note_n = 6'd0;
                        p_dur_n  = dur_inc;
                        p_next_n = HOLD;
                        state_n  = CLOSE;
                    end else begin
                        state_n = HOLD;
                    end
                end else if (dur_inc == DUR_MAX) begin
                    do_entry = 1'b1;
                    e_note   = 6'd0;
                    e_dur    = DUR_MAX;
                    dur_n    = 6'd0;
                end else begin
                    dur_n = dur_inc;
                end
            end
            CLOSE: begin
                do_entry = 1'b1;
                e_note   = p_note;
                e_dur    = p_dur;
                state_n  = p_next;
            end
            FINISH: begin
                wr_en_n   = 1'b1;
                wr_addr_n = {slot, index};
                wr_data_n = 16'h0000;
                state_n   = DONE;
            end
            DONE: begin
                if (!record_en) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Entry write shared by splits and closes; filling the slot overrides
        // whatever the state wanted next.
        if (do_entry) begin
            wr_en_n   = 1'b1;
            wr_addr_n = {slot, index};
            wr_data_n = {4'b0000, e_note, e_dur};
            index_n   = index + 1'b1;
            count_n   = note_count + 1'b1;
            if (note_count + 1'b1 == LAST_ENTRY) begin
                full_n  = 1'b1;
                state_n = FINISH;
            end
        end

        recording_n = (state_n == ARMED) || (state_n == HOLD) ||
                      (state_n == REST) || (state_n == CLOSE) ||
                      (state_n == FINISH);
    end

endmodule

// File: tb/tb_note_recorder.sv
// ---------------------------------------------------------------------------
// tb_note_recorder
//   Directed bench for note_recorder. A monitor logs every write strobe as
//   {addr, data}; each scenario queues its hand-computed writes and compares
//   them against the log, plus spot checks of the status outputs.
// ---------------------------------------------------------------------------
module tb_note_recorder;

    logic        clk = 1'b0;
    logic        reset;
    logic        record_en;
    logic [1:0]  song_select;
    logic        key_valid;
    logic [5:0]  key_note;
    logic        beat;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic        recording;
    logic        full;
    logic [4:0]  note_count;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    logic [22:0] exp_q[$];
    logic [22:0] obs_q[$];

    note_recorder dut (
        .clk        (clk),
        .reset      (reset),
        .record_en  (record_en),
        .song_select(song_select),
        .key_valid  (key_valid),
        .key_note   (key_note),
        .beat       (beat),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .recording  (recording),
        .full       (full),
        .note_count (note_count),
        .dbg_state  (dbg_state)
    );

    // ---- clock ----
    always #5 clk = ~clk;

    // ---- write monitor (one entry per cycle with wr_en high) ----
    always @(negedge clk) begin
        if (wr_en) obs_q.push_back({wr_addr, wr_data});
    end

    // ---- driver tasks ----
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            beat = 1'b1;
            tick(1);
            beat = 1'b0;
            tick(1);
        end
    endtask

    task automatic arm(input logic [1:0] sel);
        song_select = sel;
        record_en   = 1'b1;
        tick(2);
    endtask

    function automatic logic [22:0] ent(input int addr, input int nt, input int d);
        logic [6:0]  a;
        logic [15:0] w;
        a = 7'(addr);
        w = {4'b0000, 6'(nt), 6'(d)};
        return {a, w};
    endfunction

    // ---- checkers ----
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        logic [22:0] e, g;
        int n_obs, n_exp;
        n_obs = obs_q.size();
        n_exp = exp_q.size();
        checks++;
        assert (n_obs === n_exp) else begin
            errors++;
            $error("FAIL %s write_count got=%0d exp=%0d", tag, n_obs, n_exp);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (obs_q.size() > 0) ? obs_q.pop_front() : 23'h7fffff;
            checks++;
            assert (g === e) else begin
                errors++;
                $error("FAIL %s write addr/data got=%0d/%04h exp=%0d/%04h",
                       tag, g[22:16], g[15:0], e[22:16], e[15:0]);
            end
        end
        obs_q.delete();
    endtask

    // ---- watchdog ----
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---- directed sequence ----
    initial begin
        reset       = 1'b1;
        record_en   = 1'b0;
        song_select = 2'd0;
        key_valid   = 1'b0;
        key_note    = 6'd0;
        beat        = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state
        check_val("rst_wr_en", 32'(wr_en), 0);
        check_val("rst_wr_addr", 32'(wr_addr), 0);
        check_val("rst_wr_data", 32'(wr_data), 0);
        check_val("rst_recording", 32'(recording), 0);
        check_val("rst_full", 32'(full), 0);
        check_val("rst_note_count", 32'(note_count), 0);
        check_val("rst_state", 32'(dbg_state), 0);

        // 1: note 20 x5, rest x3, note 9 x2, end of take on slot 2
        arm(2'd2);
        check_val("t1_recording", 32'(recording), 1);
        check_val("t1_armed", 32'(dbg_state), 1);
        key_valid = 1'b1; key_note = 6'd20; tick(2);
        beats(5);
        key_valid = 1'b0; tick(2);
        beats(3);
        key_valid = 1'b1; key_note = 6'd9; tick(2);
        beats(2);
        record_en = 1'b0; tick(6);
        key_valid = 1'b0;
        exp_q.push_back(ent(64, 20, 5));
        exp_q.push_back(ent(65, 0, 3));
        exp_q.push_back(ent(66, 9, 2));
        exp_q.push_back(ent(67, 0, 0));
        check_writes("t1");
        check_val("t1_note_count", 32'(note_count), 3);
        check_val("t1_full", 32'(full), 0);
        check_val("t1_recording_off", 32'(recording), 0);

        // 2: tap note 7 before any beat, no rest, end take on slot 1
        arm(2'd1);
        key_valid = 1'b1; key_note = 6'd7; tick(1);
        key_valid = 1'b0; tick(2);
        record_en = 1'b0; tick(5);
        exp_q.push_back(ent(32, 7, 1));
        exp_q.push_back(ent(33, 0, 0));
        check_writes("t2");
        check_val("t2_note_count", 32'(note_count), 1);

        // 3: hold note 30 for 70 beats -> saturated split then remainder
        arm(2'd0);
        key_valid = 1'b1; key_note = 6'd30; tick(2);
        beats(70);
        key_valid = 1'b0; tick(2);
        record_en = 1'b0; tick(5);
        exp_q.push_back(ent(0, 30, 63));
        exp_q.push_back(ent(1, 30, 7));
        exp_q.push_back(ent(2, 0, 0));
        check_writes("t3");
        check_val("t3_note_count", 32'(note_count), 2);

        // 4: key change 12->13 coincident with a beat after 2 beats
        arm(2'd3);
        key_valid = 1'b1; key_note = 6'd12; tick(2);
        beats(2);
        beat = 1'b1; key_note = 6'd13; tick(1);
        beat = 1'b0; tick(1);
        beats(2);
        record_en = 1'b0; tick(5);
        key_valid = 1'b0;
        exp_q.push_back(ent(96, 12, 3));
        exp_q.push_back(ent(97, 13, 2));
        exp_q.push_back(ent(98, 0, 0));
        check_writes("t4");

        // 5: 31 taps fill slot 1; terminator at index 31; later keys ignored
        arm(2'd1);
        for (int i = 0; i < 31; i++) begin
            key_valid = 1'b1; key_note = 6'(i + 1); tick(2);
            key_valid = 1'b0; tick(2);
            exp_q.push_back(ent(32 + i, i + 1, 1));
        end
        tick(2);
        exp_q.push_back(ent(63, 0, 0));
        check_val("t5_full", 32'(full), 1);
        check_val("t5_note_count", 32'(note_count), 31);
        key_valid = 1'b1; key_note = 6'd5; tick(4);
        beats(3);
        key_valid = 1'b0; tick(4);
        check_writes("t5");
        check_val("t5_done_state", 32'(dbg_state), 6);
        check_val("t5_done_recording", 32'(recording), 0);
        check_val("t5_full_hold", 32'(full), 1);
        record_en = 1'b0; tick(2);
        check_val("t5_idle", 32'(dbg_state), 0);

        // 6: reset during HOLD after 4 beats
        arm(2'd2);
        key_valid = 1'b1; key_note = 6'd4; tick(2);
        beats(4);
        reset = 1'b1; tick(2);
        reset = 1'b0; tick(1);
        check_val("t6_wr_en", 32'(wr_en), 0);
        check_val("t6_wr_addr", 32'(wr_addr), 0);
        check_val("t6_wr_data", 32'(wr_data), 0);
        check_val("t6_recording", 32'(recording), 0);
        check_val("t6_note_count", 32'(note_count), 0);
        check_val("t6_state", 32'(dbg_state), 0);
        tick(5);
        check_val("t6_no_rearm", 32'(dbg_state), 0);
        check_writes("t6_no_write");
        record_en = 1'b0; key_valid = 1'b0; tick(2);
        arm(2'd2);
        check_val("t6_rearm", 32'(dbg_state), 1);
        record_en = 1'b0; tick(5);
        exp_q.push_back(ent(64, 0, 0));
        check_writes("t6_term");
        check_val("t6_count_after", 32'(note_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
